// File: rtl/alu_pkg.sv
// Shared definitions for the ALU-side arithmetic units (divider FSM states, widths, constants).
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

  localparam int DIV_W = 3;

  // Quotient reported on divide-by-zero is all ones; replicate this bit to the operand width.
  localparam logic DBZ_Q_BIT = 1'b1;

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor,
// keep the difference when no borrow, otherwise restore the shifted partial remainder.
module div_step #(
  parameter int WIDTH = alu_pkg::DIV_W
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] sum;
  logic             carry;

  // Subtract as add: shifted + ~{0,divisor} + 1; carry-out high means no borrow.
  always_comb begin
    shifted  = {rem, bit_in};
    sum      = {1'b0, shifted} + {1'b0, ~{1'b0, divisor}} + {{(WIDTH+1){1'b0}}, 1'b1};
    carry    = sum[WIDTH+1];
    q_bit    = carry;
    rem_next = carry ? sum[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, done pulse on completion,
// results held until the next accepted start.
module seq_divider
  import alu_pkg::*;
#(
  parameter int WIDTH = DIV_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  div_state_e       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] dvsr;
  logic [WIDTH-1:0] rem_next;
  logic             q_bit;
  logic [WIDTH-1:0] q_next;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .bit_in   (q[WIDTH-1]),
    .divisor  (dvsr),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  assign q_next = {q[WIDTH-2:0], q_bit};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      rem         <= '0;
      q           <= '0;
      dvsr        <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            dvsr <= divisor;
            if (divisor == '0) begin
              // Divide-by-zero skips RUN and presents its result on the next cycle.
              state       <= DONE;
              done        <= 1'b1;
              quotient    <= {WIDTH{DBZ_Q_BIT}};
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
              cnt   <= '0;
              rem   <= '0;
              q     <= dividend;
            end
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          rem <= rem_next;
          q   <= q_next;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state       <= DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            quotient    <= q_next;
            remainder   <= rem_next;
            div_by_zero <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider (WIDTH=3): hand-computed vectors, latency checks, and a full operand sweep.
module tb_seq_divider;

  localparam int W = 3;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int errors = 0;
  int checks = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation from the current cycle and wait for done; optionally pulse start mid-run.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eq, input logic [W-1:0] er,
                        input logic edbz, input logic glitch, input string tag);
    int lat;
    int exp_lat;
    exp_lat  = (b == 0) ? 0 : W;
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    tick();
    start    = 1'b0;
    dividend = ~a;
    divisor  = b + 3'd1;
    lat = 0;
    while (!done && lat < 12) begin
      check({tag, " busy"}, busy, 1'b1);
      if (glitch && lat == 1) begin
        start = 1'b1; dividend = 3'd1; divisor = 3'd1;
      end else begin
        start = 1'b0;
      end
      tick();
      lat++;
    end
    start = 1'b0;
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " done"}, done, 1'b1);
    check({tag, " busy@done"}, busy, 1'b0);
    check({tag, " quotient"}, quotient, eq);
    check({tag, " remainder"}, remainder, er);
    check({tag, " dbz"}, div_by_zero, edbz);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    tick(); tick();
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset quotient", quotient, 0);
    check("reset remainder", remainder, 0);
    check("reset dbz", div_by_zero, 1'b0);
    rst_n = 1'b1;
    tick();

    run_op(3'd7, 3'd2, 3'd3, 3'd1, 1'b0, 1'b0, "7/2");
    tick();
    check("7/2 done pulse", done, 1'b0);
    check("7/2 held q", quotient, 3);
    run_op(3'd5, 3'd0, 3'd7, 3'd5, 1'b1, 1'b0, "5/0");
    tick();
    run_op(3'd3, 3'd7, 3'd0, 3'd3, 1'b0, 1'b0, "3/7");
    tick();
    run_op(3'd6, 3'd3, 3'd2, 3'd0, 1'b0, 1'b0, "6/3");
    tick();
    run_op(3'd7, 3'd1, 3'd7, 3'd0, 1'b0, 1'b0, "7/1");
    tick();

    // Start pulse during RUN must be ignored.
    run_op(3'd6, 3'd4, 3'd1, 3'd2, 1'b0, 1'b1, "6/4 glitch");
    tick();
    check("glitch single done", done, 1'b0);
    check("glitch no restart", busy, 1'b0);

    // Asynchronous reset in the second RUN cycle.
    start = 1'b1; dividend = 3'd5; divisor = 3'd2;
    tick();
    start = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    check("midrst busy", busy, 1'b0);
    check("midrst done", done, 1'b0);
    check("midrst quotient", quotient, 0);
    check("midrst remainder", remainder, 0);
    tick(); tick();
    check("midrst no done", done, 1'b0);
    rst_n = 1'b1;
    tick();
    check("post-rst idle done", done, 1'b0);
    run_op(3'd4, 3'd3, 3'd1, 3'd1, 1'b0, 1'b0, "4/3");
    tick();

    // Back-to-back: second start lands on the DONE cycle of the first.
    run_op(3'd6, 3'd2, 3'd3, 3'd0, 1'b0, 1'b0, "b2b 6/2");
    run_op(3'd7, 3'd3, 3'd2, 3'd1, 1'b0, 1'b0, "b2b 7/3");
    tick();

    for (int a = 0; a < 8; a++) begin
      for (int b = 0; b < 8; b++) begin
        logic [W-1:0] eq;
        logic [W-1:0] er;
        eq = (b == 0) ? W'(7) : W'(a / b);
        er = (b == 0) ? W'(a) : W'(a % b);
        run_op(W'(a), W'(b), eq, er, (b == 0), 1'b0, $sformatf("sweep %0d/%0d", a, b));
      end
    end
    tick();
    check("final idle done", done, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
